// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory.
// Each transaction runs IDLE -> ISSUE -> COMPLETE; all outputs are registered.
module mem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [1:0]    gnt,
   output logic          MemRead,
   output logic          MemWrite,
   output logic [AW-1:0] Address,
   output logic [DW-1:0] WriteData,
   input  logic [DW-1:0] ReadData
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nx;
   logic          owner_r;
   logic          owner_nx;
   logic          we_r;
   logic          we_nx;
   logic          last_r;
   logic          last_nx;
   logic          win_s;
   logic          ack0_nx;
   logic          ack1_nx;
   logic          rd_nx;
   logic          wr_nx;
   logic [1:0]    gnt_nx;
   logic [AW-1:0] addr_nx;
   logic [DW-1:0] wdata_nx;
   logic [DW-1:0] rdata0_nx;
   logic [DW-1:0] rdata1_nx;

   // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
   assign win_s = req1 & (~req0 | ~last_r);

   // Next-state and next-output decode; Address/WriteData double as the transaction latch.
   always_comb begin
      state_nx  = state_r;
      owner_nx  = owner_r;
      we_nx     = we_r;
      last_nx   = last_r;
      gnt_nx    = gnt;
      addr_nx   = Address;
      wdata_nx  = WriteData;
      rdata0_nx = rdata0;
      rdata1_nx = rdata1;
      ack0_nx   = 1'b0;
      ack1_nx   = 1'b0;
      rd_nx     = 1'b0;
      wr_nx     = 1'b0;
      case (state_r)
         IDLE: begin
            if (req0 | req1) begin
               state_nx = ISSUE;
               owner_nx = win_s;
               gnt_nx   = win_s ? 2'b10 : 2'b01;
               we_nx    = win_s ? we1 : we0;
               addr_nx  = win_s ? addr1 : addr0;
               wdata_nx = win_s ? wdata1 : wdata0;
               rd_nx    = win_s ? ~we1 : ~we0;
               wr_nx    = win_s ? we1 : we0;
            end else begin
               state_nx = IDLE;
               gnt_nx   = 2'b00;
            end
         end
         ISSUE: begin
            state_nx = COMPLETE;
            last_nx  = owner_r;
            ack0_nx  = ~owner_r;
            ack1_nx  = owner_r;
            if (!we_r) begin
               if (owner_r) begin
                  rdata1_nx = ReadData;
               end else begin
                  rdata0_nx = ReadData;
               end
            end else begin
               rdata0_nx = rdata0;
               rdata1_nx = rdata1;
            end
         end
         COMPLETE: begin
            state_nx = IDLE;
            gnt_nx   = 2'b00;
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = 2'b00;
         end
      endcase
   end

   // State and registered outputs; reset aborts any transaction and favours port 0 next.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         owner_r   <= 1'b0;
         we_r      <= 1'b0;
         last_r    <= 1'b1;
         gnt       <= 2'b00;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         MemRead   <= 1'b0;
         MemWrite  <= 1'b0;
         Address   <= '0;
         WriteData <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         state_r   <= state_nx;
         owner_r   <= owner_nx;
         we_r      <= we_nx;
         last_r    <= last_nx;
         gnt       <= gnt_nx;
         ack0      <= ack0_nx;
         ack1      <= ack1_nx;
         MemRead   <= rd_nx;
         MemWrite  <= wr_nx;
         Address   <= addr_nx;
         WriteData <= wdata_nx;
         rdata0    <= rdata0_nx;
         rdata1    <= rdata1_nx;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8, address width to MEM and requesters.
REQ-002 Parameter DW, default 8, data width to MEM and requesters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; low = reset asserted.
REQ-005 req0 / req1  input  1 each  access request, port 0 (fetch) / port 1 (data).
REQ-006 we0 / we1  input  1 each  1 = write, 0 = read, per port.
REQ-007 addr0 / addr1  input  AW each  access address, per port.
REQ-008 wdata0 / wdata1  input  DW each  write data, per port.
REQ-009 ack0 / ack1  output  1 each  one-cycle completion pulse, per port.
REQ-010 rdata0 / rdata1  output  DW each  registered read result, per port.
REQ-011 gnt  output  2  one-hot owner of current transaction; 00 when idle.
REQ-012 MemRead / MemWrite  output  1 each  MEM strobes.
REQ-013 Address  output  AW  MEM address.
REQ-014 WriteData  output  DW  MEM write data.
REQ-015 ReadData  input  DW  MEM read data, valid the cycle after MemRead.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, COMPLETE, in that order, with no other reachable states.
- IDLE: no request -> IDLE; any request -> ISSUE.
- ISSUE -> COMPLETE unconditionally.
- COMPLETE -> IDLE unconditionally.
REQ-017 In IDLE, the arbiter SHALL sample req0/req1 at the rising edge and select a winner.
- Single requester wins.
- Both requesting: winner is the port not served last (round-robin pointer).
REQ-018 At the grant edge, the winner's we, addr and wdata SHALL be latched; later changes on those inputs SHALL NOT affect the transaction.
REQ-019 gnt SHALL be one-hot for the winner during ISSUE and COMPLETE, and 00 in IDLE.
REQ-020 During ISSUE, exactly one of MemRead/MemWrite SHALL be high per latched we; Address and WriteData SHALL carry the latched values.
REQ-021 Outside ISSUE, MemRead = MemWrite = 0; Address and WriteData SHALL hold their last values.
REQ-022 In COMPLETE, ackN of the owner SHALL be high for exactly one cycle; the other port's ack SHALL stay low.
REQ-023 On a read, the edge entering COMPLETE SHALL load ReadData into the owner's rdataN.
REQ-024 rdataN SHALL hold its value until the next read completion on port N; writes SHALL leave rdataN unchanged.
REQ-025 Latency from grant edge to ack high SHALL be 2 cycles, and back-to-back transactions SHALL occur every 3 cycles.
REQ-026 The round-robin pointer SHALL update to the served port on entry to COMPLETE.
REQ-027 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-028 Requests arriving during ISSUE/COMPLETE SHALL NOT be lost while held high; they are evaluated at the next IDLE sample.
REQ-029 Under continuous requests from both ports, grants SHALL strictly alternate, so neither port waits more than one transaction.
REQ-030 Address wrap and data width SHALL be pass-through with no arithmetic; address 0xFF SHALL be valid.

Reset
REQ-031 While rst = 0, the following SHALL hold immediately, without waiting for clk:
- state = IDLE;
- MemRead = MemWrite = 0;
- ack0 = ack1 = 0, gnt = 00;
- Address = WriteData = 0, rdata0 = rdata1 = 0;
- pointer = port 1 served last, so port 0 wins the first tie.
REQ-032 Reset asserted mid-transaction SHALL abort it with no ack; requests held through reset release SHALL be re-arbitrated from IDLE.

Verification
REQ-033 Reset: rst = 0 during ISSUE of a write -> MemWrite drops the same cycle, no ack; after release all outputs = 0.
REQ-034 Single read: mem[0x10] = 0xA5, req0 = 1, we0 = 0, addr0 = 0x10 -> MemRead high one cycle with Address = 0x10; ack0 pulses two cycles after grant; rdata0 = 0xA5.
REQ-035 Single write: req1 = 1, we1 = 1, addr1 = 0xFF, wdata1 = 0x3C -> one MemWrite cycle at 0xFF/0x3C; ack1 pulses; rdata1 unchanged. A subsequent port-0 read of 0xFF -> 0x3C.
REQ-036 Tie after reset: req0 = req1 = 1 held -> grant order 0,1,0,1; acks every 3 cycles, alternating.
REQ-037 Input change after grant: addr0 changes 0x10 -> 0x20 during ISSUE -> Address stays 0x10.
REQ-038 Held request: req0 held high for three transactions with req1 = 0 -> three port-0 acks, 3 cycles apart.
